compare_sorter: RTL

Parametrised successor to the single-pair compare block: holds a DEPTH-entry register array, sorts it in place by sequential compare-and-swap (bubble passes with early exit), and reports every swap as a dual write (address/data pairs W1/D1, W2/D2 with EN). Sits between the board-state registers and the display/update logic, which mirrors each swap through the write ports. Sorting order and signedness are parameter-selected.

---
 rtl/compare_sorter_if.sv | 32 +++
 rtl/compare_sorter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/compare_sorter_if.sv
// Load, start, readback and swap-report signals of compare_sorter.
// The sorter sits on the slave side; the controlling logic sits on the master side.
interface compare_sorter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             EN;
    logic [AW-1:0]    W1;
    logic [AW-1:0]    W2;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [15:0]      swap_cnt;

    modport master (
        output load_en, load_addr, load_data, start, rd_addr,
        input  rd_data, busy, done, EN, W1, W2, D1, D2, swap_cnt
    );

    modport slave (
        input  load_en, load_addr, load_data, start, rd_addr,
        output rd_data, busy, done, EN, W1, W2, D1, D2, swap_cnt
    );
endinterface

// File: rtl/compare_sorter.sv
// In-place bubble sorter over a DEPTH-entry register array. One adjacent
// compare per clock; every swap is reported as a dual write (W1/D1, W2/D2, EN)
// so downstream logic can mirror the array. A pass without swaps ends the sort.
module compare_sorter #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter bit SIGNED  = 1'b0,
    parameter bit DESCEND = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    compare_sorter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    pass_q, pass_d;
    logic             swapped_q, swapped_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [AW-1:0]    w1_q, w1_d, w2_q, w2_d;
    logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [WIDTH-1:0] rd_q;

    logic [AW-1:0]    idx_nxt;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             a_gt_b, a_lt_b, do_swap;

    assign idx_nxt = idx_q + AW'(1);
    assign cmp_a   = mem_q[idx_q];
    assign cmp_b   = mem_q[idx_nxt];

    // Comparator flavour is fixed at elaboration; no widening, plain compare.
    generate
        if (SIGNED) begin : g_signed
            assign a_gt_b = $signed(cmp_a) > $signed(cmp_b);
            assign a_lt_b = $signed(cmp_a) < $signed(cmp_b);
        end else begin : g_unsigned
            assign a_gt_b = cmp_a > cmp_b;
            assign a_lt_b = cmp_a < cmp_b;
        end
    endgenerate

    // Strict inequality only, so equal elements never move (stable sort).
    assign do_swap = DESCEND ? a_lt_b : a_gt_b;

    // Next-state logic: loading, pass/index sequencing, swap bookkeeping.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        w1_d      = w1_q;
        w2_d      = w2_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        case (state_q)
            IDLE: begin
                // A load in the same cycle as start still lands before the first compare.
                if (bus.load_en) begin
                    mem_d[bus.load_addr] = bus.load_data;
                end
                if (bus.start) begin
                    state_d   = COMPARE;
                    idx_d     = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            COMPARE: begin
                if (do_swap) begin
                    mem_d[idx_q]   = cmp_b;
                    mem_d[idx_nxt] = cmp_a;
                    swapped_d      = 1'b1;
                    en_d           = 1'b1;
                    w1_d           = idx_q;
                    w2_d           = idx_nxt;
                    d1_d           = cmp_b;
                    d2_d           = cmp_a;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                if (idx_q == LAST) begin
                    // The pass flag must include the swap made by this last compare.
                    if (!(swapped_q || do_swap) || pass_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        pass_d    = pass_q + AW'(1);
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_nxt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, array and report registers; reset clears everything including the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            w1_q      <= '0;
            w2_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            rd_q      <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            rd_q      <= mem_q[bus.rd_addr];
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.EN       = en_q;
    assign bus.W1       = w1_q;
    assign bus.W2       = w2_q;
    assign bus.D1       = d1_q;
    assign bus.D2       = d2_q;
    assign bus.swap_cnt = cnt_q;
endmodule
